// File: rtl/aes_pkg.sv
// Shared AES definitions for the S-box sharing scheduler: FSM encoding,
// state word count and the pass-count helper.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KW_RUN = 2'd2
  } state_e;

  localparam int AES_WORDS = 4;

  // Number of lane passes needed to cover the 4-word state.
  function automatic int pass_count(input int lanes);
    return AES_WORDS / lanes;
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, one byte in, one byte out, purely combinational.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte a sits at table offset 8*a, big-endian within the constant.
  assign y = SBOX_TBL[{a, 3'b000} +: 8];

endmodule

// File: rtl/sub_word.sv
// One 32-bit S-box lane: four byte substitutions, byte 0 = bits 0:7.
module sub_word (
  input  logic [0:31] w_in,
  output logic [0:31] w_out
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    sbox u_sbox (
      .a (w_in[8*b +: 8]),
      .y (w_out[8*b +: 8])
    );
  end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Time-shares LANES 32-bit S-box lanes between the cipher state requester
// (multi-pass SubBytes) and the key-expansion requester (single SubWord).
// Optional macro SBOX_SHARE_RR_EN: round-robin arbitration on contested
// requests; KEY_PRIO then only sets the pointer's reset value.
module sbox_share_ctrl
  import aes_pkg::*;
#(
  parameter int LANES    = 1,
  parameter bit KEY_PRIO = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [0:127] st_in,
  output logic [0:127] st_out,
  output logic         st_done,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [0:31]  kw_in,
  output logic [0:31]  kw_out,
  output logic         kw_done,
  output logic         busy
);

  localparam int         PASSES    = pass_count(LANES);
  localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);

  state_e        state_q, state_d;
  logic [1:0]    pass_q, pass_d;
  logic [0:127]  op_q, op_d;
  logic [0:127]  st_out_q, st_out_d;
  logic [0:31]   kw_out_q, kw_out_d;
  logic          st_done_q, st_done_d;
  logic          kw_done_q, kw_done_d;
  logic          key_first;

  logic [0:31]   lane_in  [LANES];
  logic [0:31]   lane_out [LANES];

`ifdef SBOX_SHARE_RR_EN
  logic          rr_q, rr_d;
  assign key_first = rr_q;
`else
  assign key_first = KEY_PRIO;
`endif

  // Grant only in IDLE; on a contest the favoured side wins.
  assign st_ready = (state_q == IDLE) && st_valid && (!kw_valid || !key_first);
  assign kw_ready = (state_q == IDLE) && kw_valid && (!st_valid ||  key_first);

  assign busy    = (state_q != IDLE);
  assign st_out  = st_out_q;
  assign kw_out  = kw_out_q;
  assign st_done = st_done_q;
  assign kw_done = kw_done_q;

  // Lane operand routing: current state pass, the key word on lane 0, else zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = '0;
      if (state_q == ST_RUN) begin
        lane_in[l] = op_q[32*(int'(pass_q)*LANES + l) +: 32];
      end else if ((state_q == KW_RUN) && (l == 0)) begin
        lane_in[l] = op_q[0:31];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sub_word u_sub_word (
      .w_in  (lane_in[g]),
      .w_out (lane_out[g])
    );
  end

  // Next-state, pass sequencing and result capture.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    op_d      = op_q;
    st_out_d  = st_out_q;
    kw_out_d  = kw_out_q;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
`ifdef SBOX_SHARE_RR_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (st_ready) begin
          state_d = ST_RUN;
          op_d    = st_in;
          pass_d  = 2'd0;
        end else if (kw_ready) begin
          state_d = KW_RUN;
          op_d    = {kw_in, 96'b0};
        end
`ifdef SBOX_SHARE_RR_EN
        // After a contested grant, favour the side that lost.
        if (st_valid && kw_valid) begin
          rr_d = ~key_first;
        end
`endif
      end
      ST_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          st_out_d[32*(int'(pass_q)*LANES + l) +: 32] = lane_out[l];
        end
        if (pass_q == LAST_PASS) begin
          state_d   = IDLE;
          st_done_d = 1'b1;
          pass_d    = 2'd0;
        end else begin
          pass_d = pass_q + 2'd1;
        end
      end
      KW_RUN: begin
        kw_out_d  = lane_out[0];
        kw_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pass_q    <= 2'd0;
      op_q      <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
`ifdef SBOX_SHARE_RR_EN
      rr_q      <= KEY_PRIO;
`endif
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      op_q      <= op_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
`ifdef SBOX_SHARE_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: LANES=1 and LANES=4 instances,
// vector tables for state and key substitution plus contest/reset sequences.
module tb_sbox_share_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;

  logic         st_valid = 1'b0, kw_valid = 1'b0;
  logic [0:127] st_in = '0;
  logic [0:31]  kw_in = '0;
  logic         st_ready, kw_ready, st_done, kw_done, busy;
  logic [0:127] st_out;
  logic [0:31]  kw_out;

  logic         st_valid4 = 1'b0, kw_valid4 = 1'b0;
  logic [0:127] st_in4 = '0;
  logic [0:31]  kw_in4 = '0;
  logic         st_ready4, kw_ready4, st_done4, kw_done4, busy4;
  logic [0:127] st_out4;
  logic [0:31]  kw_out4;

  int checks = 0;
  int errors = 0;
  bit model_ptr = 1'b1;

  always #5 clk = ~clk;

  sbox_share_ctrl #(.LANES(1), .KEY_PRIO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
    .st_out(st_out), .st_done(st_done),
    .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_in(kw_in),
    .kw_out(kw_out), .kw_done(kw_done), .busy(busy)
  );

  sbox_share_ctrl #(.LANES(4), .KEY_PRIO(1'b1)) dut4 (
    .clk(clk), .reset(reset),
    .st_valid(st_valid4), .st_ready(st_ready4), .st_in(st_in4),
    .st_out(st_out4), .st_done(st_done4),
    .kw_valid(kw_valid4), .kw_ready(kw_ready4), .kw_in(kw_in4),
    .kw_out(kw_out4), .kw_done(kw_done4), .busy(busy4)
  );

  typedef struct {
    logic [0:127] din;
    logic [0:127] dexp;
  } st_vec_t;

  typedef struct {
    logic [0:31] din;
    logic [0:31] dexp;
  } kw_vec_t;

  st_vec_t stv[3];
  kw_vec_t kwv[4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Negedges until st_done is seen on the LANES=1 instance; 99 on timeout.
  task automatic wait_st_done(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (st_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full state operation on the LANES=1 instance, uncontested.
  task automatic run_state(input logic [0:127] din, input logic [0:127] dexp, input int idx);
    int n;
    @(negedge clk);
    st_valid = 1'b1;
    st_in    = din;
    #1;
    chk($sformatf("st_ready[%0d]", idx), st_ready, 1'b1);
    @(negedge clk);
    st_valid = 1'b0;
    chk($sformatf("st_busy[%0d]", idx), busy, 1'b1);
    n = 1;
    if (!st_done) begin
      wait_st_done(n);
      n = n + 1;
    end
    chk($sformatf("st_latency[%0d]", idx), n, 5);
    chk($sformatf("st_out[%0d]", idx), st_out, dexp);
    chk($sformatf("st_busy_at_done[%0d]", idx), busy, 1'b0);
    @(negedge clk);
    chk($sformatf("st_done_single[%0d]", idx), st_done, 1'b0);
    chk($sformatf("st_out_hold[%0d]", idx), st_out, dexp);
  endtask

  task automatic run_key(input logic [0:31] din, input logic [0:31] dexp, input int idx);
    @(negedge clk);
    kw_valid = 1'b1;
    kw_in    = din;
    #1;
    chk($sformatf("kw_ready[%0d]", idx), kw_ready, 1'b1);
    @(negedge clk);
    kw_valid = 1'b0;
    chk($sformatf("kw_busy[%0d]", idx), busy, 1'b1);
    chk($sformatf("kw_done_early[%0d]", idx), kw_done, 1'b0);
    @(negedge clk);
    chk($sformatf("kw_done[%0d]", idx), kw_done, 1'b1);
    chk($sformatf("kw_out[%0d]", idx), kw_out, dexp);
    chk($sformatf("kw_busy_after[%0d]", idx), busy, 1'b0);
    @(negedge clk);
    chk($sformatf("kw_done_single[%0d]", idx), kw_done, 1'b0);
  endtask

  initial begin
    int  n;
    bit  ok;
    bit  exp_key;
    bit  saw_done;

    stv[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    stv[1] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
    stv[2] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
    kwv[0] = '{32'hcf4f3c09, 32'h8a84eb01};
    kwv[1] = '{32'h00000000, 32'h63636363};
    kwv[2] = '{32'h01020304, 32'h7c777bf2};
    kwv[3] = '{32'hffeeddcc, 32'h1628c14b};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_st_out", st_out, 128'h0);
    chk("rst_kw_out", kw_out, 32'h0);
    chk("rst_st_done", st_done, 1'b0);
    chk("rst_kw_done", kw_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    reset = 1'b0;
    #1;
    chk("idle_no_ready", {st_ready, kw_ready}, 2'b00);

    foreach (stv[i]) run_state(stv[i].din, stv[i].dexp, i);
    foreach (kwv[i]) run_key(kwv[i].din, kwv[i].dexp, i);
    chk("st_out_held_after_kw", st_out, stv[2].dexp);

    // LANES=4: single pass
    @(negedge clk);
    st_valid4 = 1'b1;
    st_in4    = 128'h0;
    #1;
    chk("l4_ready", st_ready4, 1'b1);
    @(negedge clk);
    st_valid4 = 1'b0;
    chk("l4_busy", busy4, 1'b1);
    chk("l4_done_early", st_done4, 1'b0);
    @(negedge clk);
    chk("l4_done", st_done4, 1'b1);
    chk("l4_out", st_out4, {16{8'h63}});
    @(negedge clk);
    chk("l4_done_single", st_done4, 1'b0);

    // Contest right after reset: key wins in both builds, held state follows
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 1'b1;
    st_valid = 1'b1;
    st_in    = stv[0].din;
    kw_valid = 1'b1;
    kw_in    = kwv[0].din;
    #1;
    chk("contest_grant", {kw_ready, st_ready}, 2'b10);
    model_ptr = 1'b0;
    @(negedge clk);
    kw_valid = 1'b0;
    chk("contest_busy_no_ready", st_ready, 1'b0);
    @(negedge clk);
    chk("contest_kw_done", kw_done, 1'b1);
    chk("contest_kw_out", kw_out, kwv[0].dexp);
    chk("held_st_ready_in_done", st_ready, 1'b1);
    @(negedge clk);
    st_valid = 1'b0;
    chk("held_st_running", busy, 1'b1);
    wait_st_done(n);
    chk("held_st_latency", n, 4);
    chk("held_st_out", st_out, stv[0].dexp);

    // Four contested rounds
    for (int r = 0; r < 4; r++) begin
`ifdef SBOX_SHARE_RR_EN
      exp_key = model_ptr;
`else
      exp_key = 1'b1;
`endif
      @(negedge clk);
      st_valid = 1'b1;
      st_in    = stv[2].din;
      kw_valid = 1'b1;
      kw_in    = kwv[3].din;
      #1;
      chk($sformatf("round_grant[%0d]", r), {kw_ready, st_ready}, {exp_key, ~exp_key});
      model_ptr = ~exp_key;
      @(negedge clk);
      st_valid = 1'b0;
      kw_valid = 1'b0;
      wait_idle(ok);
      chk($sformatf("round_idle[%0d]", r), ok, 1'b1);
    end

    // Reset during pass 2 of a state operation
    @(negedge clk);
    st_valid = 1'b1;
    st_in    = stv[1].din;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_st_out", st_out, 128'h0);
    chk("abort_kw_out", kw_out, 32'h0);
    chk("abort_busy", busy, 1'b0);
    saw_done = st_done;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_done = saw_done | st_done;
    end
    chk("abort_no_done", saw_done, 1'b0);
    st_valid = 1'b1;
    #1;
    chk("abort_st_ready", st_ready, 1'b1);
    @(negedge clk);
    st_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
